spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per sclk half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 start  input  1  request a transaction; sampled only in IDLE.
REQ-005 rw  input  1  1 = read, 0 = write; latched with start.
REQ-006 addr  input  7  peripheral address; latched with start.
REQ-007 wdata  input  8  write data; latched with start.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rdata  output  8  last read data.
REQ-011 sclk  output  1  SPI clock, idle low (mode 0).
REQ-012 cs  output  1  chip select, active low, idle high.
REQ-013 mosi  output  1  serial data to peripheral, MSB first.
REQ-014 miso  input  1  serial data from peripheral.

Function
REQ-015 Frame SHALL be 16 bits: A6..A0, RW, D7..D0, MSB first.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-017 IDLE->SETUP when start=1 at cycle T; addr/rw/wdata latched at T; start while busy ignored.
REQ-018 At T+1: cs=0, busy=1, mosi=A6, sclk=0.
REQ-019 Rising sclk edge k (k=0..15) SHALL occur at T+1+CLK_DIV*(1+2k); falling edge k at T+1+CLK_DIV*(2+2k).
REQ-020 mosi SHALL change only on falling sclk edges (and at T+1), so it is stable at every rising edge.
REQ-021 During data phase of a read, mosi SHALL be 0.
REQ-022 On read, miso SHALL be sampled on rising edges 8..15 into a shift register, MSB first.
REQ-023 After falling edge 15 (T+1+32*CLK_DIV), HOLD keeps cs=0, sclk=0 for CLK_DIV cycles.
REQ-024 At T+1+33*CLK_DIV: cs=1, busy=0, done=1 for one cycle; rdata updated same cycle on read, unchanged on write.
REQ-025 Earliest next start accepted the cycle after done (cs high at least one cycle between frames).
REQ-026 Default CLK_DIV=4: frame from start to done = 133 cycles.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00.
REQ-028 Reset mid-frame SHALL abort without a done pulse; first start after release begins a clean frame.

Configuration
REQ-029 Macro SPI_MASTER_LOOPBACK_EN: when defined, data-phase sampling SHALL take mosi instead of miso, for both read and write, and rdata updates at done on every transaction.
REQ-030 Without SPI_MASTER_LOOPBACK_EN, behaviour SHALL be exactly REQ-022/REQ-024; miso is the only sample source.

Structure
REQ-031 Package spi_pkg SHALL hold state enum, ADDR_W=7, DATA_W=8, FRAME_BITS=16, RW_READ=1'b1.
REQ-032 Sub-module spi_clkgen SHALL provide the CLK_DIV counter and rise/fall strobes; spi_master holds FSM and shift registers.

Verification
REQ-033 Write addr=0x00 wdata=0xFF, CLK_DIV=4 -> mosi at rising edges 0000000_0_11111111, cs low T+1..T+132, done at T+133, rdata stays 0x00.
REQ-034 Read addr=0x00, peripheral model drives 0xA5 on miso -> mosi 0000000_1_00000000, rdata=0xA5 at done.
REQ-035 start pulsed at T+50 during a frame -> ignored; exactly one done; no second frame.
REQ-036 rst_n low at T+70 -> cs=1, sclk=0, busy=0 immediately; no done; new write afterwards completes correctly.
REQ-037 CLK_DIV=1 read with miso=0x3C -> done at T+34, rdata=0x3C.
REQ-038 With SPI_MASTER_LOOPBACK_EN, write wdata=0x5A -> rdata=0x5A at done.

Source files
------------

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_pkg                                              |
// | Description : Shared widths, state encoding and frame helper for   |
// |               the SPI master.                                      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package spi_pkg;

   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 16;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } spi_state_e;

   // Outgoing frame: address, RW flag, then data (zeros on a read).
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [ADDR_W-1:0] f_addr,
      input logic              f_rw,
      input logic [DATA_W-1:0] f_wdata
   );
      build_frame = {f_addr, f_rw, (f_rw == RW_READ) ? {DATA_W{1'b0}} : f_wdata};
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_clkgen                                           |
// | Description : CLK_DIV half-period counter producing sclk rise/fall |
// |               strobes. The strobe is asserted in the cycle before  |
// |               the master's registered sclk changes level.          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;
   logic       r_phase;
   logic       w_tick;

   assign w_tick = en && (r_cnt == TERM);
   // Phase 0 means the next tick is a rising edge; the tick ending HOLD
   // therefore also appears as a rise strobe.
   assign rise   = w_tick && !r_phase;
   assign fall   = w_tick &&  r_phase;

   // Half-period counter and sclk phase, parked at zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 8'd0;
         r_phase <= 1'b0;
      end else if (!en) begin
         r_cnt   <= 8'd0;
         r_phase <= 1'b0;
      end else if (w_tick) begin
         r_cnt   <= 8'd0;
         r_phase <= !r_phase;
      end else begin
         r_cnt   <= r_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_master                                           |
// | Description : Mode-0 SPI master, 16-bit frame A6..A0,RW,D7..D0,    |
// |               MSB first. Read data sampled on rising edges 8..15. |
// |               Optional macro SPI_MASTER_LOOPBACK_EN samples mosi   |
// |               instead of miso and updates rdata on every frame.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_master import spi_pkg::*; #(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_SETUP = S_SETUP;
   localparam logic [2:0] ST_SHIFT = S_SHIFT;
   localparam logic [2:0] ST_HOLD  = S_HOLD;
   localparam logic [2:0] ST_DONE  = S_DONE;
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic [2:0]            r_state;
   logic [FRAME_BITS-1:0] r_frame;
   logic [3:0]            r_bit;
   logic                  r_sclk;
   logic [DATA_W-1:0]     r_rx;
   logic [DATA_W-1:0]     r_rdata;
   logic                  w_active;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_sample;
   logic                  w_update;

   assign w_active = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);

   spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_active),
      .rise  (w_rise),
      .fall  (w_fall)
   );

`ifdef SPI_MASTER_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = miso;
   assign w_sample      = r_frame[FRAME_BITS-1];
   assign w_update      = 1'b1;
`else
   logic r_rw;

   // Remember the transaction direction to decide whether rdata updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rw <= 1'b0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_rw <= rw;
      end
   end

   assign w_sample = miso;
   assign w_update = (r_rw == RW_READ);
`endif

   // Frame FSM: load on start, shift on falling edges, sample on rising.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_frame <= '0;
         r_bit   <= 4'd0;
         r_sclk  <= 1'b0;
         r_rx    <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_frame <= build_frame(addr, rw, wdata);
                  r_bit   <= 4'd0;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_rise) begin
                  r_sclk  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_rise) begin
                  r_sclk <= 1'b1;
                  if (r_bit[3]) begin
                     r_rx <= {r_rx[DATA_W-2:0], w_sample};
                  end
               end else if (w_fall) begin
                  // The final shift leaves the frame all-zero, so mosi idles low.
                  r_sclk  <= 1'b0;
                  r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
                  if (r_bit == LAST_BIT) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (w_rise) begin
                  r_state <= ST_DONE;
                  if (w_update) begin
                     r_rdata <= r_rx;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = w_active;
   assign cs    = !w_active;
   assign done  = (r_state == ST_DONE);
   assign sclk  = r_sclk;
   assign mosi  = r_frame[FRAME_BITS-1];
   assign rdata = r_rdata;

endmodule
`default_nettype wire
